fp_divider: RTL and testbench
=============================

# fp_divider

Sequential IEEE-754 single-precision divider computing out = in1 / in2 with the same enable/out/overflow conventions as the floating-point multiplier. It uses a 25-iteration restoring mantissa divider, handles zero operands as special cases, and reports completion with a one-cycle done pulse. It sits beside the multiplier in the FP arithmetic unit.

## Interface
Parameters: none (fixed 32-bit single precision).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  start request; a 0→1 transition sampled in IDLE starts one division
- in1  input  32  dividend; sampled on the start edge only
- in2  input  32  divisor; sampled on the start edge only
- out  output  32  quotient; holds its value until the next completion
- overflow  output  1  result exponent was out of range and has been wrapped
- div_by_zero  output  1  divisor was zero
- done  output  1  one-cycle pulse on the cycle out becomes valid
- busy  output  1  high from the start edge until completion

## Operation
- Reset (reset=0, async): out=0, overflow=0, div_by_zero=0, done=0, busy=0, state=IDLE, enable-history register=0, iteration counter=0.
- Start condition: state IDLE, enable=1 and enable-history=0. enable-history samples enable on every edge.
  - If enable is already high when reset releases, exactly one operation starts.
  - Holding enable high starts no further operations.
  - Enable activity outside IDLE is ignored.
- Operand decode:
  - sign = in1[31]^in2[31]; e1, e2 = exponent fields; m = {1, fraction}, 24 bits.
  - An exponent field of 0 means the operand is zero (denormals flush to zero).
  - An exponent field of 255 is treated as an ordinary exponent; there is no Inf/NaN handling.
- States:
  - IDLE: on start, capture operands and set busy=1. Go to FINISH if a special case applies, otherwise go to DIVIDE with rem = m1 (25 bits) and count = 0.
  - DIVIDE: one iteration per cycle. If rem ≥ m2, set q bit = 1 and rem = rem − m2; otherwise set q bit = 0. Then shift rem left by 1. Quotient bits fill MSB first into q[24:0]. After 25 iterations (count = 24), go to FINISH.
  - FINISH: write out and the flags, pulse done=1, clear busy, return to IDLE.
- Normalization (FINISH, normal path):
  - If q[24]=1: mantissa = q[23:1], E = e1 − e2 + 127.
  - If q[24]=0: mantissa = q[22:0], E = e1 − e2 + 126.
  - Rounding is truncation (round toward zero).
  - E is computed in 10-bit signed arithmetic.
- Exponent range:
  - If E > 254 or E < 1: overflow=1 and the exponent field = E[7:0] (wrap-around, same as the multiplier convention).
  - Otherwise overflow=0.
- Special cases (all with overflow=0):
  - Dividend zero, divisor nonzero: out = 0x00000000 (positive zero regardless of sign), div_by_zero=0.
  - Dividend nonzero, divisor zero: out = {sign, 0xFF, 0}, div_by_zero=1.
  - Both zero: out = 0x7FC00000, div_by_zero=1.
- Flag lifetime:
  - overflow and div_by_zero are rewritten at every completion.
  - out and the flags hold between completions.
- Reset mid-operation: the operation aborts, no done pulse is produced, and all outputs take their reset values.

## Timing
- Start edge is E0.
- Normal path:
  - DIVIDE iterations on E1..E25.
  - FINISH on E26 updates out and flags; done=1 and busy=0 during the cycle after E26.
  - Latency: 26 cycles.
- Special path: FINISH on E1, so latency is 1 cycle.
- done is high for exactly one cycle. busy is high during the cycles after E0 through E25 (normal) or after E0 only (special).
- Earliest restart:
  - A new operation can start on the edge after done, provided enable has been seen low for at least one sampled edge.
  - Back-to-back operations therefore require enable low for ≥1 cycle.

## Test plan
- Normal quotient:
  - 0x40F68000 / 0xC0080000 → out=0xC0680000, overflow=0, done exactly 26 cycles after start.
  - 0xBF820000 / 0x3FD00000 → out=0xBF200000.
- Identity and normalization:
  - 0x40480000 / 0x3F800000 → out=0x40480000 (q[24]=1 path).
  - 0x3F800000 / 0x40000000 → out=0x3F000000 (q[24]=0 path).
- Zeros:
  - 0x00000000 / 0xC0480000 → out=0x00000000, div_by_zero=0, done 1 cycle after start.
  - 0xC0A80000 / 0x00000000 → out=0xFF800000, div_by_zero=1.
  - 0x00000000 / 0x00000000 → out=0x7FC00000, div_by_zero=1.
- Exponent wrap:
  - 0x7F000000 / 0x00800000 → out=0x3E000000, overflow=1.
  - 0x00800000 / 0x7F000000 → out=0x41000000, overflow=1.
- Handshake:
  - enable held high for 60 cycles → exactly one done pulse.
  - Toggle enable while busy → ignored; out is unchanged until the first result.
- Reset mid-DIVIDE (cycle 10) → all outputs 0 immediately (async), no done pulse. A new start after release completes correctly.

Source files
------------

// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE-754 single-precision divider using a 25-step restoring mantissa divide
module fp_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out,
    output logic        overflow,
    output logic        div_by_zero,
    output logic        done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [24:0] q_q, q_d;
    logic [23:0] m2_q, m2_d;
    logic [7:0]  e1_q, e1_d, e2_q, e2_d;
    logic        sign_q, sign_d, z1_q, z1_d, z2_q, z2_d;
    logic [31:0] out_q, out_d;
    logic        ovf_q, ovf_d, dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;
    logic        ge;
    logic [24:0] diff;
    logic [9:0]  e_w;
    logic        ovf_w;
    logic [22:0] mant_w;

    always_comb begin
        state_d = state_q;
        en_d    = enable;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        m2_d    = m2_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        sign_d  = sign_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ge      = rem_q >= {1'b0, m2_q};
        diff    = ge ? rem_q - {1'b0, m2_q} : rem_q;
        e_w     = {2'b00, e1_q} - {2'b00, e2_q} + (q_q[24] ? 10'd127 : 10'd126);
        ovf_w   = ($signed(e_w) > 10'sd254) || ($signed(e_w) < 10'sd1);
        mant_w  = q_q[24] ? q_q[23:1] : q_q[22:0];
        case (state_q)
            IDLE: begin
                if (enable && !en_q) begin
                    sign_d  = in1[31] ^ in2[31];
                    e1_d    = in1[30:23];
                    e2_d    = in2[30:23];
                    z1_d    = in1[30:23] == 8'd0;
                    z2_d    = in2[30:23] == 8'd0;
                    m2_d    = {1'b1, in2[22:0]};
                    rem_d   = {2'b01, in1[22:0]};
                    q_d     = 25'd0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = (in1[30:23] == 8'd0 || in2[30:23] == 8'd0) ? FINISH : DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d   = {diff[23:0], 1'b0};
                q_d     = {q_q[23:0], ge};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd24 ? FINISH : DIVIDE;
            end
            FINISH: begin
                out_d   = (z1_q && z2_q) ? 32'h7FC00000 :
                          z2_q ? {sign_q, 8'hFF, 23'd0} :
                          z1_q ? 32'd0 : {sign_q, e_w[7:0], mant_w};
                ovf_d   = !(z1_q || z2_q) && ovf_w;
                dbz_d   = z2_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            cnt_q   <= 5'd0;
            rem_q   <= 25'd0;
            q_q     <= 25'd0;
            m2_q    <= 24'd0;
            e1_q    <= 8'd0;
            e2_q    <= 8'd0;
            sign_q  <= 1'b0;
            z1_q    <= 1'b0;
            z2_q    <= 1'b0;
            out_q   <= 32'd0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            m2_q    <= m2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            sign_q  <= sign_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign out         = out_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign done        = done_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: scoreboard bench for fp_divider with directed vectors
module tb_fp_divider;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic [31:0] out;
    logic        overflow, div_by_zero, done, busy;

    typedef struct {
        logic [31:0] o;
        logic        ov;
        logic        dz;
        int          lat;
        int          st;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ncomp = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fp_divider dut (
        .clk(clk), .reset(reset), .enable(enable), .in1(in1), .in2(in2),
        .out(out), .overflow(overflow), .div_by_zero(div_by_zero), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            ncomp++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("out", out, e.o);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                chk("latency", cyc - e.st, e.lat);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic push(input logic [31:0] o, input logic ov, input logic dz, input int lat);
        exp_t e;
        e.o = o; e.ov = ov; e.dz = dz; e.lat = lat; e.st = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_comp(input int tgt);
        int k = 0;
        while (ncomp < tgt && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (ncomp < tgt) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d completions expected %0d", ncomp, tgt);
        end
        @(negedge clk);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] o,
                         input logic ov, input logic dz, input int lat);
        int tgt;
        @(negedge clk);
        tgt = ncomp + 1;
        in1 = a;
        in2 = b;
        enable = 1'b1;
        push(o, ov, dz, lat);
        @(negedge clk);
        enable = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_comp(tgt);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_op(32'h40F68000, 32'hC0080000, 32'hC0680000, 1'b0, 1'b0, 26);
        do_op(32'hBF820000, 32'h3FD00000, 32'hBF200000, 1'b0, 1'b0, 26);
        do_op(32'h40480000, 32'h3F800000, 32'h40480000, 1'b0, 1'b0, 26);
        do_op(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, 1'b0, 26);
        do_op(32'h00000000, 32'hC0480000, 32'h00000000, 1'b0, 1'b0, 1);
        do_op(32'hC0A80000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1, 1);
        do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1);
        do_op(32'h7F000000, 32'h00800000, 32'h3E000000, 1'b1, 1'b0, 26);

        // enable held high: only one operation
        @(negedge clk);
        base = ncomp;
        in1 = 32'h40480000;
        in2 = 32'h3F800000;
        enable = 1'b1;
        push(32'h40480000, 1'b0, 1'b0, 26);
        repeat (60) @(negedge clk);
        enable = 1'b0;
        chk("hold_one_done", ncomp - base, 32'd1);
        repeat (2) @(negedge clk);

        // enable toggles while busy are ignored
        base = ncomp;
        in1 = 32'h40F68000;
        in2 = 32'hC0080000;
        enable = 1'b1;
        push(32'hC0680000, 1'b0, 1'b0, 26);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enable = i[0];
            in1 = 32'h3F800000;
            in2 = 32'h40000000;
            if (i == 5) chk("out_hold_mid", out, 32'h40480000);
        end
        enable = 1'b0;
        chk("out_hold_late", out, 32'h40480000);
        wait_comp(base + 1);
        repeat (30) @(negedge clk);
        chk("toggle_one_done", ncomp - base, 32'd1);

        do_op(32'h00800000, 32'h7F000000, 32'h41000000, 1'b1, 1'b0, 26);

        // abort in the middle of DIVIDE
        @(negedge clk);
        base = ncomp;
        in1 = 32'h40F68000;
        in2 = 32'hC0080000;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done", ncomp - base, 32'd0);

        do_op(32'hBF820000, 32'h3FD00000, 32'hBF200000, 1'b0, 1'b0, 26);
        chk("queue_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule
